ppu_vram_arbiter: RTL
=====================

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

Interface
REQ-001 SHALL have parameter CPU_STARVE_LIMIT, default 16, meaning waiting cycles after which the CPU wins arbitration.
REQ-002 SHALL have PPU_SLOW_CLOCK  in  1  sole clock; all state changes on posedge.
REQ-003 SHALL have RST_N  in  1  reset: synchronous and active-low.
REQ-004 SHALL have RENDERING  in  1  high during visible scanlines with rendering enabled.
REQ-005 SHALL have BG_REQ  in  1  background fetch request.
REQ-006 SHALL have BG_ADDR  in  14  background fetch address.
REQ-007 SHALL have BG_GNT  out  1  background grant pulse.
REQ-008 SHALL have SPR_REQ  in  1  sprite fetch request.
REQ-009 SHALL have SPR_ADDR  in  14  sprite fetch address.
REQ-010 SHALL have SPR_GNT  out  1  sprite grant pulse.
REQ-011 SHALL have CPU_REQ  in  1  PPUDATA access request.
REQ-012 SHALL have CPU_WE  in  1  CPU access is a write.
REQ-013 SHALL have CPU_ADDR  in  14  CPU access address.
REQ-014 SHALL have CPU_WDATA  in  8  CPU write data.
REQ-015 SHALL have CPU_GNT  out  1  CPU grant pulse.
REQ-016 SHALL have APPU  out  14  VRAM address.
REQ-017 SHALL have PPUDO  out  8  VRAM write data.
REQ-018 SHALL have MEM_WE  out  1  VRAM write strobe.
REQ-019 SHALL have PPUDI  in  8  VRAM read data, valid the cycle after APPU is presented.
REQ-020 SHALL have RDATA  out  8  registered read data.
REQ-021 SHALL have RD_VALID  out  1  access-complete pulse.
REQ-022 SHALL have RD_OWNER  out  2  completing requester: 0 BG, 1 SPR, 2 CPU.

Function
REQ-023 SHALL implement states IDLE, ADDR, DATA; each access occupies ADDR then DATA, i.e. one access per 2 cycles.
REQ-024 SHALL arbitrate in IDLE and DATA; on a winner, the next state is ADDR, else IDLE.
REQ-025 SHALL assert the winner's GNT for exactly the ADDR cycle, with APPU holding the winner's address, registered at arbitration.
REQ-026 SHALL, for a CPU write, drive MEM_WE=1 and PPUDO=CPU_WDATA during ADDR only; MEM_WE=0 at all other times.
REQ-027 SHALL capture PPUDI into RDATA at the end of DATA and pulse RD_VALID with RD_OWNER for one cycle after DATA.
REQ-028 SHALL leave RDATA unchanged on write completion (RD_VALID still pulses, RD_OWNER=2).
REQ-029 SHALL give request-to-RD_VALID latency of 3 cycles from an idle bus: REQ sampled at edge t, GNT in t+1, RD_VALID in t+3.
REQ-030 SHALL use priority BG>SPR>CPU when RENDERING=1, and CPU>SPR>BG when RENDERING=0.
REQ-031 SHALL keep a 5-bit CPU wait counter: +1 per cycle CPU_REQ=1 and not granted, saturating at 31, cleared on CPU grant or CPU_REQ=0.
REQ-032 SHALL make the CPU win regardless of RENDERING when the wait counter >= CPU_STARVE_LIMIT.
REQ-033 SHALL allow a requester to drop REQ before its grant (withdrawal, no access); a REQ still high after GNT is a new request.
REQ-034 SHALL sample RENDERING only at arbitration; a change mid-access does not affect the access in flight.
REQ-035 SHALL resolve simultaneous requests in one cycle, with no idle gap between back-to-back grants.

Reset
REQ-036 SHALL, while RST_N=0 at a posedge, set state IDLE, all GNT/MEM_WE/RD_VALID=0, APPU=0, PPUDO=0, RDATA=0, RD_OWNER=0, wait counter=0.
REQ-037 SHALL discard an access in flight when reset occurs mid-operation, with no RD_VALID; arbitration resumes the first cycle after RST_N=1.

Verification
REQ-038 SHALL cover: RENDERING=0, CPU read 0x2005 with PPUDI=0xA7 -> CPU_GNT in t+1, APPU=0x2005, RD_VALID/RD_OWNER=2/RDATA=0xA7 in t+3.
REQ-039 SHALL cover: RENDERING=1, all three requests held -> grants BG, BG, ... every 2 cycles, SPR never while BG_REQ=1, CPU granted after 16 waiting cycles.
REQ-040 SHALL cover: CPU write 0x3F00=0x21 -> MEM_WE=1, PPUDO=0x21 for exactly 1 cycle, RD_VALID with RDATA unchanged.
REQ-041 SHALL cover: SPR_REQ pulsed 1 cycle while BG busy, then dropped -> no SPR_GNT, no SPR RD_VALID.
REQ-042 SHALL cover: RST_N=0 during DATA -> next cycle all outputs 0, no RD_VALID; a request held through reset is granted 1 cycle after release.

Source files
------------

// File: rtl/ppu_vram_arbiter_if.sv
// VRAM arbitration bus: background/sprite/CPU request ports, the VRAM-side
// address/data pins and the completion report back to the requesters.
interface ppu_vram_arbiter_if;
    logic        RENDERING;
    logic        BG_REQ;
    logic [13:0] BG_ADDR;
    logic        BG_GNT;
    logic        SPR_REQ;
    logic [13:0] SPR_ADDR;
    logic        SPR_GNT;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [13:0] CPU_ADDR;
    logic [7:0]  CPU_WDATA;
    logic        CPU_GNT;
    logic [13:0] APPU;
    logic [7:0]  PPUDO;
    logic        MEM_WE;
    logic [7:0]  PPUDI;
    logic [7:0]  RDATA;
    logic        RD_VALID;
    logic [1:0]  RD_OWNER;

    // Arbiter side
    modport slave (
        input  RENDERING, BG_REQ, BG_ADDR, SPR_REQ, SPR_ADDR,
               CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, PPUDI,
        output BG_GNT, SPR_GNT, CPU_GNT, APPU, PPUDO, MEM_WE,
               RDATA, RD_VALID, RD_OWNER
    );

    // Requester / memory side
    modport master (
        output RENDERING, BG_REQ, BG_ADDR, SPR_REQ, SPR_ADDR,
               CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, PPUDI,
        input  BG_GNT, SPR_GNT, CPU_GNT, APPU, PPUDO, MEM_WE,
               RDATA, RD_VALID, RD_OWNER
    );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// Two-cycle (ADDR, DATA) VRAM access arbiter for the PPU background, sprite
// and CPU ports, with rendering-dependent priority and CPU starvation relief.
module ppu_vram_arbiter #(
    parameter int unsigned CPU_STARVE_LIMIT = 16
) (
    input  logic              PPU_SLOW_CLOCK,
    input  logic              RST_N,
    ppu_vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    localparam logic [1:0] OWN_BG  = 2'd0;
    localparam logic [1:0] OWN_SPR = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;

    state_t      state_q, state_d;
    logic [4:0]  wait_cnt_q, wait_cnt_d;
    logic        bg_gnt_q, bg_gnt_d;
    logic        spr_gnt_q, spr_gnt_d;
    logic        cpu_gnt_q, cpu_gnt_d;
    logic [13:0] appu_q, appu_d;
    logic [7:0]  ppudo_q, ppudo_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic [1:0]  rd_owner_q, rd_owner_d;
    logic [1:0]  owner_q, owner_d;
    logic        wr_q, wr_d;

    logic        arb_slot;
    logic        starve;
    logic        win_vld;
    logic [1:0]  win_owner;
    logic        cpu_win;

    // Winner selection; only meaningful when arb_slot is set
    always_comb begin
        arb_slot  = (state_q != ADDR);
        starve    = bus.CPU_REQ && (32'(wait_cnt_q) >= CPU_STARVE_LIMIT);
        win_vld   = 1'b1;
        win_owner = OWN_BG;
        if (starve) begin
            win_owner = OWN_CPU;
        end else if (bus.RENDERING) begin
            if (bus.BG_REQ)       win_owner = OWN_BG;
            else if (bus.SPR_REQ) win_owner = OWN_SPR;
            else if (bus.CPU_REQ) win_owner = OWN_CPU;
            else                  win_vld   = 1'b0;
        end else begin
            if (bus.CPU_REQ)      win_owner = OWN_CPU;
            else if (bus.SPR_REQ) win_owner = OWN_SPR;
            else if (bus.BG_REQ)  win_owner = OWN_BG;
            else                  win_vld   = 1'b0;
        end
        cpu_win = arb_slot && win_vld && (win_owner == OWN_CPU);
    end

    always_comb begin
        state_d    = state_q;
        bg_gnt_d   = 1'b0;
        spr_gnt_d  = 1'b0;
        cpu_gnt_d  = 1'b0;
        appu_d     = appu_q;
        ppudo_d    = 8'h00;
        mem_we_d   = 1'b0;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        rd_owner_d = rd_owner_q;
        owner_d    = owner_q;
        wr_d       = wr_q;

        if (!bus.CPU_REQ || cpu_win)  wait_cnt_d = 5'd0;
        else if (wait_cnt_q == 5'd31) wait_cnt_d = wait_cnt_q;
        else                          wait_cnt_d = wait_cnt_q + 5'd1;

        case (state_q)
            ADDR: state_d = DATA;
            DATA: begin
                // Memory returns data during DATA; writes keep the last read value
                rd_valid_d = 1'b1;
                rd_owner_d = owner_q;
                if (!wr_q) rdata_d = bus.PPUDI;
            end
            default: ;
        endcase

        if (arb_slot) begin
            if (win_vld) begin
                state_d = ADDR;
                owner_d = win_owner;
                wr_d    = 1'b0;
                case (win_owner)
                    OWN_BG: begin
                        bg_gnt_d = 1'b1;
                        appu_d   = bus.BG_ADDR;
                    end
                    OWN_SPR: begin
                        spr_gnt_d = 1'b1;
                        appu_d    = bus.SPR_ADDR;
                    end
                    default: begin
                        cpu_gnt_d = 1'b1;
                        appu_d    = bus.CPU_ADDR;
                        wr_d      = bus.CPU_WE;
                        mem_we_d  = bus.CPU_WE;
                        if (bus.CPU_WE) ppudo_d = bus.CPU_WDATA;
                    end
                endcase
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            wait_cnt_q <= 5'd0;
            bg_gnt_q   <= 1'b0;
            spr_gnt_q  <= 1'b0;
            cpu_gnt_q  <= 1'b0;
            appu_q     <= 14'd0;
            ppudo_q    <= 8'h00;
            mem_we_q   <= 1'b0;
            rdata_q    <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 2'd0;
            owner_q    <= 2'd0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bg_gnt_q   <= bg_gnt_d;
            spr_gnt_q  <= spr_gnt_d;
            cpu_gnt_q  <= cpu_gnt_d;
            appu_q     <= appu_d;
            ppudo_q    <= ppudo_d;
            mem_we_q   <= mem_we_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.BG_GNT   = bg_gnt_q;
    assign bus.SPR_GNT  = spr_gnt_q;
    assign bus.CPU_GNT  = cpu_gnt_q;
    assign bus.APPU     = appu_q;
    assign bus.PPUDO    = ppudo_q;
    assign bus.MEM_WE   = mem_we_q;
    assign bus.RDATA    = rdata_q;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.RD_OWNER = rd_owner_q;
endmodule
